sr_flop_bank: RTL
=================

Name: sr_flop_bank

Overview:
- Parametrised, clocked successor to the gate-level NAND SR latch.
- N independent SR storage channels on one clock, each with:
  - input debounce/qualification,
  - a configurable resolution for the S=R=1 code,
  - a sticky invalid-code flag,
  - a one-cycle change pulse.
- Sits between raw control/status strobes and downstream logic that needs glitch-free, always-complementary set/reset state.

Parameters:
- N, 4: number of channels.
- FILT, 2: cycles a registered (set,reset) pair must stay unchanged before it acts; legal range 1..15.
- BOTH_MODE, 0: action on qualified S=R=1. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.
- INIT, 0: reset value of every q bit (0 or 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- set  in  N  per-channel set request, level, may be asynchronous/glitchy.
- reset  in  N  per-channel reset request, level.
- clr_err  in  N  per-channel synchronous clear of invalid.
- q  out  N  stored state.
- qb  out  N  complement of q.
- chg  out  N  one-cycle pulse when q changed at the previous edge.
- invalid  out  N  sticky: a qualified S=R=1 was seen.
- err_cnt  out  8*N  per-channel invalid-event count, channel i at [8i+7:8i]; only live with ERR_COUNT_EN.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - q = {N{INIT}}, qb = ~q, chg = 0, invalid = 0, err_cnt = 0.
  - Input regs s_d/r_d = 0, stability counters = 0, qualified flags = 0.
- Input stage: s_d, r_d register set/reset every edge (one flop stage; synchroniser depth is the integrator's concern).
- Stability counter per channel, 4-bit, cnt:
  - If {s_d,r_d} changes at an edge, cnt <= 0.
  - Otherwise cnt increments, saturating at FILT-1.
- The pair is qualified while cnt == FILT-1 and {s_d,r_d} is unchanged.
- Latency:
  - Input stable before edge E0 is captured at E0.
  - q updates at edge E0+FILT.
  - FILT=1 gives 1-cycle latency after capture.
  - Pulses narrower than FILT cycles (as sampled) have no effect.
- Qualified actions:
  - 10 -> q <= 1.
  - 01 -> q <= 0.
  - 00 -> hold.
  - 11 -> per BOTH_MODE.
- Level actions (set, reset, dominant modes) re-apply every qualified cycle; they are idempotent.
- Toggle (mode 3) fires exactly once, at the first qualified edge of a stable 11 run. It does not toggle again until the pair changes and re-qualifies as 11.
- qb is always ~q; never both 1. This differs from the NAND latch 00 case.
- chg[i] = 1 for exactly the cycle after any edge where q[i] changed.
- invalid[i]:
  - Set at the first qualified edge of each 11 run, in all modes.
  - Cleared by clr_err[i] at an edge.
  - Simultaneous new 11 qualification and clr_err: set wins.
- Channels are fully independent; no cross-channel priority.
- rst_n asserted mid-run aborts counting; after release every channel must requalify from cnt=0.

Optional Feature:
- Macro: SR_FLOP_BANK_ERR_COUNT_EN.
- Defined:
  - Each channel has an 8-bit counter, incremented at each invalid-setting event.
  - Saturates at 255.
  - Cleared by clr_err[i] unless an event occurs the same edge. Then the counter loads 1 if clr_err is asserted, else increments.
  - Driven on err_cnt.
- Undefined: no counters synthesised; err_cnt tied to 0. Port list unchanged.

Test Plan:
- Reset: N=4, INIT=1, assert rst_n=0 mid-cycle -> q=4'hF, qb=0, chg=0, invalid=0 immediately, without waiting for a clock edge.
- Latency/debounce: FILT=3, set[0] high from before E0 -> q[0]=1 after E3, chg[0]=1 for one cycle. A 2-cycle set[1] pulse -> q[1] unchanged.
- Reset request: q[2]=1, reset[2] held 5 cycles with FILT=2 -> q[2]=0 after E2, qb[2]=1, one chg pulse only.
- Both-high modes, set=reset=1 held 6 cycles, q initially 0:
  - mode 0 -> q stays 0.
  - mode 1 -> q=1.
  - mode 2 -> q=0.
  - mode 3 -> q=1, one toggle only.
  - invalid=1 in all modes.
  - Drop to 00 for FILT cycles, reapply 11 in mode 3 -> q toggles back to 0.
- Clear priority: clr_err[3] asserted at the same edge as a new 11 qualification -> invalid[3] stays 1. clr_err alone next cycle -> invalid[3]=0.
- With SR_FLOP_BANK_ERR_COUNT_EN: 300 separate qualified 11 runs on ch0 -> err_cnt[7:0]=255, then clr_err[0] -> 0. Without the macro, err_cnt = 0 throughout.

Source files
------------

// File: rtl/sr_flop_bank.sv
// N-channel clocked SR storage bank with input qualification, S=R=1 policy, sticky invalid flag and change pulse.
// Optional per-channel invalid-event counters are built when SR_FLOP_BANK_ERR_COUNT_EN is defined.
module sr_flop_bank #(
  parameter int N         = 4,
  parameter int FILT      = 2,
  parameter int BOTH_MODE = 0,
  parameter bit INIT      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     set,
  input  logic [N-1:0]     reset,
  input  logic [N-1:0]     clr_err,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qb,
  output logic [N-1:0]     chg,
  output logic [N-1:0]     invalid,
  output logic [8*N-1:0]   err_cnt
);

  typedef enum logic [1:0] {
    BOTH_HOLD   = 2'd0,
    BOTH_SET    = 2'd1,
    BOTH_RESET  = 2'd2,
    BOTH_TOGGLE = 2'd3
  } both_e;

  localparam both_e      MODE    = both_e'(BOTH_MODE[1:0]);
  localparam logic [3:0] CNT_MAX = 4'(FILT - 1);

  logic [N-1:0] s_d, r_d;
  logic [N-1:0] seen;        // current stable run has already qualified once
  logic [N-1:0] pair_chg, qual, first11;
  logic [N-1:0] q_next, inv_next;
  logic [3:0]   cnt [N];

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    pair_chg = '0;
    qual     = '0;
    first11  = '0;
    q_next   = q;
    inv_next = invalid;
    for (int i = 0; i < N; i++) begin
      pair_chg[i] = (set[i] != s_d[i]) || (reset[i] != r_d[i]);
      qual[i]     = !pair_chg[i] && (cnt[i] == CNT_MAX);
      first11[i]  = qual[i] && !seen[i] && s_d[i] && r_d[i];
      if (qual[i]) begin
        case ({s_d[i], r_d[i]})
          2'b10: q_next[i] = 1'b1;
          2'b01: q_next[i] = 1'b0;
          2'b11: begin
            case (MODE)
              BOTH_SET:    q_next[i] = 1'b1;
              BOTH_RESET:  q_next[i] = 1'b0;
              BOTH_TOGGLE: if (!seen[i]) q_next[i] = ~q[i];
              default:     ;
            endcase
          end
          default: ;
        endcase
      end
      // A fresh S=R=1 qualification beats a same-edge clear.
      if (first11[i])      inv_next[i] = 1'b1;
      else if (clr_err[i]) inv_next[i] = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d     <= '0;
      r_d     <= '0;
      seen    <= '0;
      q       <= {N{INIT}};
      chg     <= '0;
      invalid <= '0;
      // NOTE: the counter array is only N nibbles, so it is reset like any other state.
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s_d     <= set;
      r_d     <= reset;
      q       <= q_next;
      chg     <= q_next ^ q;
      invalid <= inv_next;
      for (int i = 0; i < N; i++) begin
        if (pair_chg[i]) begin
          cnt[i]  <= '0;
          seen[i] <= 1'b0;
        end else begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 4'd1;
          if (qual[i]) seen[i] <= 1'b1;
        end
      end
    end
  end

  assign qb = ~q;

`ifdef SR_FLOP_BANK_ERR_COUNT_EN
  logic [7:0] ecnt [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) ecnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (first11[i]) begin
          if (clr_err[i])             ecnt[i] <= 8'd1;
          else if (ecnt[i] != 8'hFF)  ecnt[i] <= ecnt[i] + 8'd1;
        end else if (clr_err[i]) begin
          ecnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < N; i++) err_cnt[8*i +: 8] = ecnt[i];
  end
`else
  assign err_cnt = '0;
`endif

endmodule
